// File: rtl/ltc_align_ctrl.sv
// LTC217x link-training controller: bitslip frame alignment, IDELAY eye sweep,
// eye centring and frame loss-of-lock monitoring, all in the CLKDIV domain.
module ltc_align_ctrl #(
  parameter logic [7:0]  FRAME_PAT = 8'hF0,
  parameter logic [13:0] TEST_PAT  = 14'h2AAA,
  parameter logic [4:0]  DEF_TAP   = 5'd12,
  parameter int          SETTLE    = 16,
  parameter int          CHECK     = 64,
  parameter int          MIN_EYE   = 4,
  parameter int          MAX_SLIP  = 16,
  parameter int          LOSS_CNT  = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [7:0]  iFrame,
  input  logic [13:0] iData,
  output logic        oBitSlip,
  output logic [4:0]  oIdlyCnt,
  output logic        oIdlyLd,
  output logic        oBusy,
  output logic        oLocked,
  output logic        oErr,
  output logic [4:0]  oEyeLo,
  output logic [4:0]  oEyeHi
);

  // state     | meaning
  // IDLE      | waiting for iStart
  // SLIP      | test frame word, pulse BITSLIP or begin the sweep
  // SLIP_WAIT | let the ISERDES settle after a bitslip
  // TAP_LOAD  | IDELAY load of the current sweep tap in flight
  // SETTLE    | let the IDELAY settle before comparing
  // CHECK     | compare data/frame against the expected patterns
  // NEXT_TAP  | fold the tap result into run/best-eye tracking
  // CENTER    | pick the centre of the widest eye, or give up
  // DONE      | locked, watching the frame lane for loss of lock
  // FAIL      | training failed, default tap reloaded
  typedef enum logic [3:0] {
    ST_IDLE, ST_SLIP, ST_SLIP_WAIT, ST_TAP_LOAD, ST_SETTLE,
    ST_CHECK, ST_NEXT_TAP, ST_CENTER, ST_DONE, ST_FAIL
  } state_t;

  localparam logic [6:0] SETTLE_LD  = 7'(SETTLE - 1);
  localparam logic [6:0] CHECK_LD   = 7'(CHECK - 1);
  localparam logic [5:0] MAX_SLIP_V = 6'(MAX_SLIP);
  localparam logic [5:0] MIN_EYE_V  = 6'(MIN_EYE);
  localparam logic [3:0] LOSS_LD    = 4'(LOSS_CNT - 1);

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [5:0]  slips_q, slips_d;
  logic [4:0]  tap_q, tap_d;
  logic        pass_q, pass_d;
  logic        run_vld_q, run_vld_d;
  logic [4:0]  run_lo_q, run_lo_d;
  logic [4:0]  run_hi_q, run_hi_d;
  logic [4:0]  best_lo_q, best_lo_d;
  logic [4:0]  best_hi_q, best_hi_d;
  logic [5:0]  best_len_q, best_len_d;
  logic [3:0]  loss_q, loss_d;
  logic        bitslip_q, bitslip_d;
  logic [4:0]  idly_cnt_q, idly_cnt_d;
  logic        idly_ld_q, idly_ld_d;
  logic        busy_q, busy_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic [4:0]  eye_lo_q, eye_lo_d;
  logic [4:0]  eye_hi_q, eye_hi_d;

  logic        frame_ok;
  logic        data_ok;
  logic [4:0]  center;
  logic [5:0]  run_len;
  logic        start_train;
  logic        enter_fail;

  assign frame_ok = (iFrame == FRAME_PAT);
  assign data_ok  = (iData == TEST_PAT);
  // 6-bit sum so lo+hi cannot wrap before halving
  assign center   = 5'(({1'b0, best_lo_q} + {1'b0, best_hi_q}) >> 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slips_d     = slips_q;
    tap_d       = tap_q;
    pass_d      = pass_q;
    run_vld_d   = run_vld_q;
    run_lo_d    = run_lo_q;
    run_hi_d    = run_hi_q;
    best_lo_d   = best_lo_q;
    best_hi_d   = best_hi_q;
    best_len_d  = best_len_q;
    loss_d      = loss_q;
    bitslip_d   = 1'b0;
    idly_cnt_d  = idly_cnt_q;
    idly_ld_d   = 1'b0;
    locked_d    = locked_q;
    err_d       = err_q;
    eye_lo_d    = eye_lo_q;
    eye_hi_d    = eye_hi_q;
    run_len     = '0;
    start_train = 1'b0;
    enter_fail  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (iStart) start_train = 1'b1;
      end
      ST_SLIP: begin
        if (frame_ok) begin
          tap_d      = '0;
          idly_cnt_d = '0;
          idly_ld_d  = 1'b1;
          state_d    = ST_TAP_LOAD;
        end else if (slips_q == MAX_SLIP_V) begin
          enter_fail = 1'b1;
        end else begin
          bitslip_d = 1'b1;
          slips_d   = slips_q + 6'd1;
          cnt_d     = SETTLE_LD;
          state_d   = ST_SLIP_WAIT;
        end
      end
      ST_SLIP_WAIT: begin
        if (cnt_q == '0) state_d = ST_SLIP;
        else             cnt_d   = cnt_q - 7'd1;
      end
      ST_TAP_LOAD: begin
        cnt_d   = SETTLE_LD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = CHECK_LD;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      ST_CHECK: begin
        if (!data_ok || !frame_ok) begin
          pass_d  = 1'b0;
          state_d = ST_NEXT_TAP;
        end else if (cnt_q == '0) begin
          pass_d  = 1'b1;
          state_d = ST_NEXT_TAP;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      ST_NEXT_TAP: begin
        if (pass_q) begin
          run_vld_d = 1'b1;
          run_hi_d  = tap_q;
          if (!run_vld_q) run_lo_d = tap_q;
          run_len = 6'({1'b0, run_hi_d} - {1'b0, run_lo_d} + 6'd1);
          // strict compare keeps the earliest eye on a tie
          if (run_len > best_len_q) begin
            best_lo_d  = run_lo_d;
            best_hi_d  = run_hi_d;
            best_len_d = run_len;
          end
        end else begin
          run_vld_d = 1'b0;
        end
        if (tap_q == 5'd31) begin
          state_d = ST_CENTER;
        end else begin
          tap_d      = tap_q + 5'd1;
          idly_cnt_d = tap_q + 5'd1;
          idly_ld_d  = 1'b1;
          state_d    = ST_TAP_LOAD;
        end
      end
      ST_CENTER: begin
        if (best_len_q >= MIN_EYE_V) begin
          eye_lo_d   = best_lo_q;
          eye_hi_d   = best_hi_q;
          idly_cnt_d = center;
          idly_ld_d  = 1'b1;
          locked_d   = 1'b1;
          loss_d     = LOSS_LD;
          state_d    = ST_DONE;
        end else begin
          enter_fail = 1'b1;
        end
      end
      ST_DONE: begin
        if (iStart) begin
          start_train = 1'b1;
        end else if (frame_ok) begin
          loss_d = LOSS_LD;
        end else if (loss_q == '0) begin
          start_train = 1'b1;
        end else begin
          loss_d = loss_q - 4'd1;
        end
      end
      ST_FAIL: begin
        if (iStart) start_train = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_train) begin
      state_d    = ST_SLIP;
      locked_d   = 1'b0;
      err_d      = 1'b0;
      slips_d    = '0;
      run_vld_d  = 1'b0;
      best_lo_d  = '0;
      best_hi_d  = '0;
      best_len_d = '0;
      eye_lo_d   = '0;
      eye_hi_d   = '0;
    end
    if (enter_fail) begin
      state_d    = ST_FAIL;
      err_d      = 1'b1;
      locked_d   = 1'b0;
      idly_cnt_d = DEF_TAP;
      idly_ld_d  = 1'b1;
    end
  end

  assign busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_FAIL);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      slips_q    <= '0;
      tap_q      <= '0;
      pass_q     <= 1'b0;
      run_vld_q  <= 1'b0;
      run_lo_q   <= '0;
      run_hi_q   <= '0;
      best_lo_q  <= '0;
      best_hi_q  <= '0;
      best_len_q <= '0;
      loss_q     <= '0;
      bitslip_q  <= 1'b0;
      idly_cnt_q <= DEF_TAP;
      idly_ld_q  <= 1'b0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      eye_lo_q   <= '0;
      eye_hi_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slips_q    <= slips_d;
      tap_q      <= tap_d;
      pass_q     <= pass_d;
      run_vld_q  <= run_vld_d;
      run_lo_q   <= run_lo_d;
      run_hi_q   <= run_hi_d;
      best_lo_q  <= best_lo_d;
      best_hi_q  <= best_hi_d;
      best_len_q <= best_len_d;
      loss_q     <= loss_d;
      bitslip_q  <= bitslip_d;
      idly_cnt_q <= idly_cnt_d;
      idly_ld_q  <= idly_ld_d;
      busy_q     <= busy_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      eye_lo_q   <= eye_lo_d;
      eye_hi_q   <= eye_hi_d;
    end
  end

  assign oBitSlip = bitslip_q;
  assign oIdlyCnt = idly_cnt_q;
  assign oIdlyLd  = idly_ld_q;
  assign oBusy    = busy_q;
  assign oLocked  = locked_q;
  assign oErr     = err_q;
  assign oEyeLo   = eye_lo_q;
  assign oEyeHi   = eye_hi_q;

endmodule

// File: tb/tb_ltc_align_ctrl.sv
// Bench for ltc_align_ctrl: deserializer/ADC behavioural model driven by a
// per-tap pass mask and a slip-count frame model, checked against an eye model.
`timescale 1ns/1ps
module tb_ltc_align_ctrl;
  logic        iClk = 1'b0;
  logic        iRst, iStart;
  logic [7:0]  iFrame;
  logic [13:0] iData;
  logic        oBitSlip, oIdlyLd, oBusy, oLocked, oErr;
  logic [4:0]  oIdlyCnt, oEyeLo, oEyeHi;

  int errors = 0;
  int checks = 0;

  logic [31:0] pass_mask;
  logic [13:0] bad_val [32];
  int          need_slips;
  bit          frame_corrupt;
  int          slip_seen, cyc, last_slip, min_gap, width_viol, last_ld;
  bit          prev_slip, prev_ld;
  int          ld_q[$];

  ltc_align_ctrl dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iFrame(iFrame), .iData(iData),
    .oBitSlip(oBitSlip), .oIdlyCnt(oIdlyCnt), .oIdlyLd(oIdlyLd), .oBusy(oBusy),
    .oLocked(oLocked), .oErr(oErr), .oEyeLo(oEyeLo), .oEyeHi(oEyeHi)
  );

  always #5 iClk = ~iClk;

  // Deserializer/ADC model: frame aligns after need_slips bitslips, data
  // matches the test pattern only at taps set in pass_mask.
  always @(negedge iClk) begin
    cyc++;
    if (oBitSlip === 1'b1) begin
      if (prev_slip) width_viol++;
      if (slip_seen > 0 && cyc - last_slip < min_gap) min_gap = cyc - last_slip;
      last_slip = cyc;
      slip_seen++;
    end
    if (oIdlyLd === 1'b1) begin
      if (prev_ld) width_viol++;
      ld_q.push_back(int'(oIdlyCnt));
      last_ld = int'(oIdlyCnt);
    end
    prev_slip = (oBitSlip === 1'b1);
    prev_ld   = (oIdlyLd === 1'b1);
    iFrame = frame_corrupt ? 8'h0F : ((slip_seen >= need_slips) ? 8'hF0 : 8'hE1);
    iData  = pass_mask[oIdlyCnt] ? 14'h2AAA : bad_val[oIdlyCnt];
  end

  // Widest run of consecutive passing taps, earliest on a tie.
  function automatic void ref_eye(input logic [31:0] m, output int lo, output int hi,
                                  output int len);
    int s;
    len = 0; lo = 0; hi = 0; s = -1;
    for (int t = 0; t <= 32; t++) begin
      if (t < 32 && m[t]) begin
        if (s < 0) s = t;
      end else if (s >= 0) begin
        if (t - s > len) begin
          len = t - s; lo = s; hi = t - 1;
        end
        s = -1;
      end
    end
  endfunction

  task automatic run_train(input logic [31:0] mask, input int need);
    bit lat_a, timed_out;
    @(posedge iClk); #2;
    pass_mask = mask; need_slips = need; slip_seen = 0; ld_q.delete();
    min_gap = 1000000; width_viol = 0; last_ld = -1;
    for (int i = 0; i < 32; i++) bad_val[i] = 14'h2AAA ^ 14'($urandom_range(1, 16383));
    @(negedge iClk); iStart = 1'b1;
    @(negedge iClk); iStart = 1'b0;
    lat_a = oBitSlip | oIdlyLd;
    @(negedge iClk);
    checks++;
    if (lat_a !== 1'b0 || (oBitSlip | oIdlyLd) !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: pulse at cycle1=%0b cycle2=%0b, required 0 then 1",
               lat_a, oBitSlip | oIdlyLd);
    end
    timed_out = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge iClk);
      if (oBusy === 1'b0) begin timed_out = 1'b0; break; end
    end
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL train_timeout: oBusy still %0b after 6000 cycles, required 0", oBusy);
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({oBitSlip, oIdlyLd, oBusy, oLocked, oErr, oEyeLo, oEyeHi} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all 0",
               {oBitSlip, oIdlyLd, oBusy, oLocked, oErr, oEyeLo, oEyeHi});
    end
    checks++;
    if (oIdlyCnt !== 5'd12) begin
      errors++; $display("FAIL reset_tap: got %0d, required 12", oIdlyCnt);
    end
    @(negedge iClk); iRst = 1'b0;
    repeat (3) @(negedge iClk);
  endtask

  task automatic test_all_pass();
    int bad;
    run_train(32'hFFFF_FFFF, 0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (i >= ld_q.size() || ld_q[i] != i) bad++;
    checks++;
    if (ld_q.size() != 33 || bad != 0 || last_ld != 15) begin
      errors++;
      $display("FAIL all_pass_loads: count=%0d misordered=%0d last=%0d, required 33/0/15",
               ld_q.size(), bad, last_ld);
    end
    checks++;
    if (slip_seen != 0 || width_viol != 0) begin
      errors++; $display("FAIL all_pass_slips: slips=%0d widthviol=%0d, required 0/0",
                         slip_seen, width_viol);
    end
    checks++;
    if (oEyeLo !== 5'd0 || oEyeHi !== 5'd31 || oIdlyCnt !== 5'd15 || oLocked !== 1'b1 ||
        oErr !== 1'b0) begin
      errors++;
      $display("FAIL all_pass_result: lo=%0d hi=%0d tap=%0d lock=%0b err=%0b, required 0/31/15/1/0",
               oEyeLo, oEyeHi, oIdlyCnt, oLocked, oErr);
    end
  endtask

  task automatic test_slips();
    run_train(32'hFFFF_FFFF, 3);
    checks++;
    if (slip_seen != 3 || min_gap < 16 || width_viol != 0) begin
      errors++;
      $display("FAIL three_slips: slips=%0d mingap=%0d widthviol=%0d, required 3/>=16/0",
               slip_seen, min_gap, width_viol);
    end
    checks++;
    if (ld_q.size() < 1 || ld_q[0] != 0 || oLocked !== 1'b1) begin
      errors++;
      $display("FAIL slips_sweep_start: loads=%0d lock=%0b, required first load tap 0 and lock 1",
               ld_q.size(), oLocked);
    end
  endtask

  task automatic test_two_eyes();
    logic [31:0] m;
    m = '0;
    for (int b = 6; b <= 17; b++) m[b] = 1'b1;
    for (int b = 22; b <= 24; b++) m[b] = 1'b1;
    run_train(m, 0);
    checks++;
    if (oEyeLo !== 5'd6 || oEyeHi !== 5'd17 || oIdlyCnt !== 5'd11 || oLocked !== 1'b1) begin
      errors++;
      $display("FAIL two_eyes: lo=%0d hi=%0d tap=%0d lock=%0b, required 6/17/11/1",
               oEyeLo, oEyeHi, oIdlyCnt, oLocked);
    end
  endtask

  task automatic test_small_eye();
    run_train(32'h0000_0038, 0);
    checks++;
    if (oErr !== 1'b1 || oLocked !== 1'b0 || oIdlyCnt !== 5'd12 || last_ld != 12 ||
        ld_q.size() != 33) begin
      errors++;
      $display("FAIL small_eye: err=%0b lock=%0b tap=%0d lastld=%0d loads=%0d, required 1/0/12/12/33",
               oErr, oLocked, oIdlyCnt, last_ld, ld_q.size());
    end
  endtask

  task automatic test_no_frame();
    run_train(32'hFFFF_FFFF, 1000);
    checks++;
    if (slip_seen != 16 || oErr !== 1'b1 || ld_q.size() != 1 || last_ld != 12 ||
        oIdlyCnt !== 5'd12) begin
      errors++;
      $display("FAIL no_frame: slips=%0d err=%0b loads=%0d lastld=%0d tap=%0d, required 16/1/1/12/12",
               slip_seen, oErr, ld_q.size(), last_ld, oIdlyCnt);
    end
    run_train(32'hFFFF_FFFF, 0);
    checks++;
    if (oErr !== 1'b0 || oLocked !== 1'b1 || oIdlyCnt !== 5'd15) begin
      errors++;
      $display("FAIL restart_after_fail: err=%0b lock=%0b tap=%0d, required 0/1/15",
               oErr, oLocked, oIdlyCnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] m;
    int lo, hi, len, need, nr, s, ln;
    for (int it = 0; it < 8; it++) begin
      m = '0;
      nr = $urandom_range(1, 3);
      for (int k = 0; k < nr; k++) begin
        s  = $urandom_range(0, 31);
        ln = $urandom_range(1, 10);
        for (int b = s; b < s + ln && b < 32; b++) m[b] = 1'b1;
      end
      need = $urandom_range(0, 6);
      ref_eye(m, lo, hi, len);
      run_train(m, need);
      checks++;
      if (slip_seen != need || width_viol != 0) begin
        errors++;
        $display("FAIL rand_slips it=%0d: slips=%0d widthviol=%0d, required %0d/0",
                 it, slip_seen, width_viol, need);
      end
      checks++;
      if (len >= 4) begin
        if (oLocked !== 1'b1 || oErr !== 1'b0 || oEyeLo !== 5'(lo) || oEyeHi !== 5'(hi) ||
            oIdlyCnt !== 5'((lo + hi) / 2) || ld_q.size() != 33) begin
          errors++;
          $display("FAIL rand_eye it=%0d mask=%h: lock=%0b lo=%0d hi=%0d tap=%0d loads=%0d, required 1/%0d/%0d/%0d/33",
                   it, m, oLocked, oEyeLo, oEyeHi, oIdlyCnt, ld_q.size(), lo, hi, (lo + hi) / 2);
        end
      end else begin
        if (oErr !== 1'b1 || oLocked !== 1'b0 || oIdlyCnt !== 5'd12 || last_ld != 12) begin
          errors++;
          $display("FAIL rand_fail it=%0d mask=%h: err=%0b lock=%0b tap=%0d lastld=%0d, required 1/0/12/12",
                   it, m, oErr, oLocked, oIdlyCnt, last_ld);
        end
      end
    end
  endtask

  task automatic test_loss_of_lock();
    run_train(32'hFFFF_FFFF, 0);
    @(posedge iClk); #2 frame_corrupt = 1'b1;
    repeat (3) @(posedge iClk);
    #2 frame_corrupt = 1'b0;
    repeat (5) @(negedge iClk);
    checks++;
    if (oLocked !== 1'b1 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL glitch3_keeps_lock: lock=%0b busy=%0b, required 1/0", oLocked, oBusy);
    end
    @(posedge iClk); #2 frame_corrupt = 1'b1;
    repeat (4) @(posedge iClk);
    #2 frame_corrupt = 1'b0;
    @(negedge iClk);
    checks++;
    if (oLocked !== 1'b0 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL glitch4_loses_lock: lock=%0b busy=%0b, required 0/1", oLocked, oBusy);
    end
    repeat (25) @(negedge iClk);
    checks++;
    if (oBusy !== 1'b1 || oIdlyCnt !== 5'd0) begin
      errors++;
      $display("FAIL retrain_in_check: busy=%0b tap=%0d, required 1/0", oBusy, oIdlyCnt);
    end
    #2 iRst = 1'b1;
    #1;
    checks++;
    if ({oBitSlip, oIdlyLd, oBusy, oLocked, oErr, oEyeLo, oEyeHi} !== '0 ||
        oIdlyCnt !== 5'd12) begin
      errors++;
      $display("FAIL async_reset_mid_check: flags=%b tap=%0d, required all 0 and tap 12",
               {oBitSlip, oIdlyLd, oBusy, oLocked, oErr, oEyeLo, oEyeHi}, oIdlyCnt);
    end
    @(negedge iClk); iRst = 1'b0;
    repeat (3) @(negedge iClk);
    checks++;
    if (oBusy !== 1'b0 || oIdlyCnt !== 5'd12 || oIdlyLd !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%0b tap=%0d ld=%0b, required 0/12/0",
               oBusy, oIdlyCnt, oIdlyLd);
    end
  endtask

  initial begin
    iRst = 1'b1; iStart = 1'b0; iFrame = 8'hF0; iData = 14'h2AAA;
    frame_corrupt = 1'b0; pass_mask = '1; need_slips = 0;
    slip_seen = 0; cyc = 0; last_slip = 0; min_gap = 1000000; width_viol = 0;
    last_ld = -1; prev_slip = 1'b0; prev_ld = 1'b0;
    for (int i = 0; i < 32; i++) bad_val[i] = 14'h1555;
    test_reset();
    test_all_pass();
    test_slips();
    test_two_eyes();
    test_small_eye();
    test_no_frame();
    test_random();
    test_loss_of_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
